lcd_write_sequencer: RTL and testbench
======================================

// Module: lcd_write_sequencer
// PURPOSE
//  Timed controller for the Spartan-3E 2x16 character LCD in 4-bit mode, with a valid/ready byte-write port.
//  On reset it runs the power-on init (0x3,0x3,0x3,0x2 nibbles) and config (0x28,0x06,0x0C,0x01), then raises init_done.
//  After init, each accepted command (rs=0) or data (rs=1) byte is sent as two E-strobed nibbles with datasheet timing.
//  It replaces free-running count-decoded LCD sequencing. Upstream display/debug logic is the sole requester.
// PARAMETERS
//  T_PWR    750000  cycles of power-on wait before the first init nibble (15 ms @ 50 MHz)
//  T_INIT1  205000  wait after init nibble 1 (4.1 ms)
//  T_INIT2  5000    wait after init nibble 2 (100 us)
//  T_CMD    2000    wait after any byte, and after init nibbles 3/4 (40 us)
//  T_CLEAR  82000   wait after clear or home, i.e. cmd byte 0x01/0x02/0x03 (1.64 ms)
//  T_GAP    50      wait between the upper and lower nibble of one byte (1 us)
//  T_SETUP  2       cycles rs/nibble must be stable before E rises
//  T_PULSE  12      E high cycles (240 ns)
//  T_HOLD   1       cycles rs/nibble are held after E falls
//  CNT_W    20      delay counter width; must hold the largest T_* parameter
// PORTS
//  clk         in   1  system clock (50 MHz)
//  rst         in   1  synchronous, active-high reset
//  wr_valid    in   1  requester has a byte to write
//  wr_rs       in   1  0 = command, 1 = DDRAM/CGRAM data
//  wr_data     in   8  byte to write
//  wr_ready    out  1  sequencer can accept a byte this cycle
//  init_done   out  1  init and config sequence complete
//  sf_e        out  1  StrataFlash disable / LCD access; constant 1
//  lcd_e       out  1  LCD enable strobe
//  lcd_rs      out  1  LCD register select
//  lcd_rw      out  1  LCD read/write; constant 0 (write only, busy flag never read)
//  lcd_nibble  out  4  LCD DB[7:4]
// BEHAVIOUR
//  Reset values: wr_ready=0, init_done=0, sf_e=1, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_nibble=0.
//  All outputs are registered.
//  A reset asserted mid-transfer aborts it in the same edge: lcd_e=0, the byte is lost, and init restarts at PWR_WAIT.
//  States: PWR_WAIT -> INIT_NIB(k=0..3) -> CFG(j=0..3) -> IDLE -> XFER_HI -> GAP -> XFER_LO -> BYTE_WAIT -> IDLE.
//  INIT_NIB: nibble k is written alone with rs=0, then the FSM waits T_INIT1, T_INIT2, T_CMD, T_CMD for k=0..3.
//  CFG: ROM byte j is sent as a full byte, identical to XFER. The wait after 0x01 is T_CLEAR.
//  init_done rises on the cycle IDLE is first entered and stays high until reset.
//  wr_ready = 1 only in IDLE. Transfer occurs on a cycle with wr_valid & wr_ready.
//  On transfer, wr_rs/wr_data are latched and wr_ready drops on the next cycle.
//  wr_valid is ignored while wr_ready=0, including during init; no queueing.
//  Nibble write (one per XFER phase):
//   - lcd_rs and lcd_nibble are driven for T_SETUP cycles;
//   - then lcd_e=1 for T_PULSE cycles;
//   - then lcd_e=0 for T_HOLD cycles;
//   - lcd_rs and lcd_nibble stay stable across the whole window.
//  Byte order: upper nibble [7:4] first, then GAP for T_GAP cycles, then lower nibble [3:0].
//  BYTE_WAIT lasts T_CLEAR if rs=0 and data is 0x01..0x03; otherwise T_CMD. Then the FSM returns to IDLE.
//  Byte-to-byte spacing with wr_valid held high:
//   - normal byte = 2*(T_SETUP+T_PULSE+T_HOLD) + T_GAP + T_CMD + 1 cycles
//   - clear/home byte: the same with T_CLEAR in place of T_CMD.
//  Delay counter loads T-1 on state entry and counts down to 0, so each wait is exactly T cycles. No wrap is possible.
//  After the final wait, lcd_e=0 and lcd_nibble/lcd_rs hold their last values.
// STRUCTURE
//  lcd_pkg: FSM state encoding, init-nibble table, wait-select table, CFG ROM {0x28,0x06,0x0C,0x01}, and the 0x01..0x03 long-command set.
//  Sub-module lcd_nibble_writer (start, rs, nib -> lcd_e/lcd_rs/lcd_nibble, done):
//   - implements the SETUP/PULSE/HOLD timing;
//   - done is a 1-cycle pulse after HOLD;
//   - it is reused by INIT_NIB and both XFER phases.
//  Top level holds the sequencing FSM, the delay counter, and the handshake register.
// TESTING (small params: T_PWR=20,T_INIT1=10,T_INIT2=6,T_CMD=4,T_CLEAR=9,T_GAP=3)
//  1 Reset release:
//    - lcd_e stays 0 for 20 cycles;
//    - then 4 init pulses carry nibbles 3,3,3,2 with rs=0;
//    - pulse spacing reflects waits 10/6/4/4.
//  2 Config:
//    - 8 E pulses carry nibbles 2,8,0,6,0,C,0,1;
//    - a 9-cycle wait follows the last pulse;
//    - init_done=1 and wr_ready=1 on the next cycle.
//  3 Data write wr_rs=1, wr_data=0x48:
//    - nibbles 4 then 8 with rs=1;
//    - 12-cycle E pulses, 3-cycle gap;
//    - wr_ready returns after a 4-cycle wait.
//  4 Command 0x01 then data 0x65 held valid back-to-back:
//    - the first byte's final wait is 9 cycles, the second's is 4;
//    - exactly two transfers occur;
//    - a scoreboard checks nibble order and the setup/hold windows.
//  5 wr_valid=1 with 0x41 during init: no E pulses beyond the init/config set; 0x41 is accepted only once wr_ready=1.
//  6 rst pulsed while lcd_e=1 in XFER_LO:
//    - next cycle lcd_e=0, wr_ready=0, init_done=0;
//    - the full init sequence repeats from PWR_WAIT.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the Spartan-3E character LCD write sequencer.
// Holds FSM encodings, the power-on nibble table, wait selection and config ROM.
// Helper functions keep the tables in one place for the top and the bench.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT_NIB,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_XFER_HI,
    ST_GAP,
    ST_XFER_LO,
    ST_BYTE_WAIT
  } state_e;

  typedef enum logic [1:0] {
    NW_IDLE,
    NW_SETUP,
    NW_PULSE,
    NW_HOLD
  } nw_state_e;

  // Which delay follows a given step; mapped to cycle counts in the top.
  typedef enum logic [1:0] {
    WS_INIT1,
    WS_INIT2,
    WS_CMD,
    WS_CLEAR
  } wait_sel_e;

  localparam int NUM_INIT = 4;
  localparam int NUM_CFG  = 4;

  // Power-on nibbles written alone: 0x3, 0x3, 0x3, 0x2 (switch to 4-bit mode).
  function automatic logic [3:0] init_nibble(input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd3:    n = 4'h2;
      default: n = 4'h3;
    endcase
    return n;
  endfunction

  // Delay after each power-on nibble.
  function automatic wait_sel_e init_wait_sel(input logic [1:0] k);
    wait_sel_e w;
    case (k)
      2'd0:    w = WS_INIT1;
      2'd1:    w = WS_INIT2;
      default: w = WS_CMD;
    endcase
    return w;
  endfunction

  // Config ROM: function set, entry mode, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] j);
    logic [7:0] b;
    case (j)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Clear and home commands need the long post-byte delay.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d >= 8'h01) && (d <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Writes one nibble to the LCD bus: rs/nibble setup, E pulse, then hold.
// Latency: T_SETUP+T_PULSE+T_HOLD cycles from start; done marks the last hold cycle.
// No backpressure: start is only honoured while idle, the caller sequences around done.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] nib_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [3:0] lcd_nibble_o,
  output logic       done_o
);

  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);

  nw_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [3:0]    nib_q, nib_d;

  // Phase sequencing; rs/nibble only change when a new nibble starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    case (state_q)
      NW_IDLE: begin
        if (start_i) begin
          rs_d    = rs_i;
          nib_d   = nib_i;
          cnt_d   = C_SETUP;
          state_d = NW_SETUP;
        end
      end
      NW_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = C_PULSE;
          state_d = NW_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      NW_PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = C_HOLD;
          state_d = NW_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      NW_HOLD: begin
        if (cnt_q == '0) begin
          state_d = NW_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = NW_IDLE;
    endcase
  end

  // State and bus registers; reset drops E immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NW_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
    end
  end

  // done overlaps the final hold cycle so the caller's next wait starts without a bubble.
  assign done_o       = (state_q == NW_HOLD) && (cnt_q == '0);
  assign lcd_e_o      = e_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_nibble_o = nib_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// LCD init/config sequencer with a valid/ready byte-write port (4-bit bus mode).
// Latency: a byte occupies 2*(setup+pulse+hold)+gap+post-byte wait cycles after acceptance.
// Backpressure: wr_ready is high only in IDLE; wr_valid is ignored otherwise (no queueing).
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000,
  parameter int T_GAP   = 50,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       sf_e,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_nibble
);

  localparam logic [CNT_W-1:0] C_PWR   = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] C_INIT1 = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] C_INIT2 = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] C_CLEAR = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(T_GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       k_q, k_d;
  logic [1:0]       j_q, j_d;
  logic             cfg_q, cfg_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             wr_ready_q, wr_ready_d;
  logic             init_done_q, init_done_d;
  logic             sf_e_q, lcd_rw_q;

  logic             nw_start, nw_rs, nw_done;
  logic [3:0]       nw_nib;
  logic             ld_byte, ld_rs;
  logic [7:0]       ld_dat;

  function automatic logic [CNT_W-1:0] wait_cnt(input wait_sel_e w);
    logic [CNT_W-1:0] c;
    case (w)
      WS_INIT1: c = C_INIT1;
      WS_INIT2: c = C_INIT2;
      WS_CMD:   c = C_CMD;
      default:  c = C_CLEAR;
    endcase
    return c;
  endfunction

  // Sequencing FSM: next state, delay counter loads, nibble-writer start requests.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    j_d         = j_q;
    cfg_d       = cfg_q;
    rs_d        = rs_q;
    data_d      = data_q;
    wr_ready_d  = wr_ready_q;
    init_done_d = init_done_q;
    nw_start    = 1'b0;
    nw_rs       = rs_q;
    nw_nib      = data_q[3:0];
    ld_byte     = 1'b0;
    ld_rs       = 1'b0;
    ld_dat      = 8'h00;
    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_INIT_NIB;
          k_d      = 2'd0;
          nw_start = 1'b1;
          nw_rs    = 1'b0;
          nw_nib   = init_nibble(2'd0);
        end
      end
      ST_INIT_NIB: begin
        if (nw_done) begin
          state_d = ST_INIT_WAIT;
          cnt_d   = wait_cnt(init_wait_sel(k_q));
        end
      end
      ST_INIT_WAIT: begin
        if (cnt_q == '0) begin
          if (k_q == 2'(NUM_INIT - 1)) begin
            cfg_d   = 1'b1;
            j_d     = 2'd0;
            ld_byte = 1'b1;
            ld_dat  = cfg_byte(2'd0);
          end else begin
            state_d  = ST_INIT_NIB;
            k_d      = k_q + 2'd1;
            nw_start = 1'b1;
            nw_rs    = 1'b0;
            nw_nib   = init_nibble(k_q + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        if (wr_valid && wr_ready_q) begin
          ld_byte    = 1'b1;
          ld_rs      = wr_rs;
          ld_dat     = wr_data;
          wr_ready_d = 1'b0;
        end
      end
      ST_XFER_HI: begin
        if (nw_done) begin
          state_d = ST_GAP;
          cnt_d   = C_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d  = ST_XFER_LO;
          nw_start = 1'b1;
        end
      end
      ST_XFER_LO: begin
        if (nw_done) begin
          state_d = ST_BYTE_WAIT;
          cnt_d   = is_long_cmd(rs_q, data_q) ? C_CLEAR : C_CMD;
        end
      end
      ST_BYTE_WAIT: begin
        if (cnt_q == '0) begin
          if (cfg_q && (j_q != 2'(NUM_CFG - 1))) begin
            j_d     = j_q + 2'd1;
            ld_byte = 1'b1;
            ld_dat  = cfg_byte(j_q + 2'd1);
          end else begin
            state_d     = ST_IDLE;
            cfg_d       = 1'b0;
            wr_ready_d  = 1'b1;
            init_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
    // Config bytes and host bytes share the same byte path from here.
    if (ld_byte) begin
      state_d  = ST_XFER_HI;
      rs_d     = ld_rs;
      data_d   = ld_dat;
      nw_start = 1'b1;
      nw_rs    = ld_rs;
      nw_nib   = ld_dat[7:4];
    end
  end

  // Sequencer registers; reset restarts the whole power-on sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= C_PWR;
      k_q         <= 2'd0;
      j_q         <= 2'd0;
      cfg_q       <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
      sf_e_q      <= 1'b1;
      lcd_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      j_q         <= j_d;
      cfg_q       <= cfg_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      wr_ready_q  <= wr_ready_d;
      init_done_q <= init_done_d;
      sf_e_q      <= 1'b1;
      lcd_rw_q    <= 1'b0;
    end
  end

  lcd_nibble_writer #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD),
    .CW      (8)
  ) u_nw (
    .clk          (clk),
    .rst          (rst),
    .start_i      (nw_start),
    .rs_i         (nw_rs),
    .nib_i        (nw_nib),
    .lcd_e_o      (lcd_e),
    .lcd_rs_o     (lcd_rs),
    .lcd_nibble_o (lcd_nibble),
    .done_o       (nw_done)
  );

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign sf_e      = sf_e_q;
  assign lcd_rw    = lcd_rw_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer with shortened delays.
// Stimulus pushes expected E pulses; a negedge monitor pops and checks them.
// Timing of pulses, gaps and wr_ready return is checked against hand-computed counts.
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready, init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_nibble;

  lcd_write_sequencer #(
    .T_PWR(20), .T_INIT1(10), .T_INIT2(6), .T_CMD(4), .T_CLEAR(9), .T_GAP(3),
    .T_SETUP(2), .T_PULSE(12), .T_HOLD(1), .CNT_W(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_rs      (wr_rs),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .init_done  (init_done),
    .sf_e       (sf_e),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_nibble (lcd_nibble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;  // expected E-low cycles before this pulse, -1 = unchecked
    int         rdy;  // E-low cycles from fall until wr_ready, -1 = none expected
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Init + config: nibbles 3,3,3,2 then 0x28,0x06,0x0C,0x01 split into nibbles.
  int init_nib [12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
  // Low cycles before each rise: hold + wait + setup (22 = power-on 20 + setup 2).
  int init_gap [12] = '{22, 13, 9, 7, 7, 6, 7, 6, 7, 6, 7, 6};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_init();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.rs  = 1'b0;
      e.nib = 4'(init_nib[i]);
      e.gap = init_gap[i];
      e.rdy = (i == 11) ? 11 : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_t e;
    logic long_w;
    long_w = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    e.rs = rs; e.nib = d[7:4]; e.gap = -1; e.rdy = -1;
    exp_q.push_back(e);
    e.nib = d[3:0]; e.gap = 6; e.rdy = long_w ? 11 : 6;
    exp_q.push_back(e);
  endtask

  // Waits for a handshake seen at negedge (it completes at the next posedge).
  task automatic wait_accept(output int acc_cyc);
    logic got;
    got = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
        chk("accept_only_after_init", init_done, 1);
        push_byte(wr_rs, wr_data);
      end
    end
    chk("accept_timeout", got, 1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3000 && !wr_ready; i++) @(negedge clk);
    chk("ready_timeout", wr_ready, 1);
  endtask

  // Monitor state
  int         low_cnt, high_cnt, rdy_tgt, cur_rdy;
  logic       prev_e, rdy_pend, stab_bad;
  logic [4:0] cur, pulse_val, h1, h2;
  exp_t       ex;

  always @(negedge clk) begin
    cur = {lcd_rs, lcd_nibble};
    if (rst) begin
      low_cnt = 0; high_cnt = 0; prev_e = 1'b0; rdy_pend = 1'b0;
      stab_bad = 1'b0; cur_rdy = -1;
    end else begin
      if (lcd_e && !prev_e) begin
        chk("pulse_expected", exp_q.size() != 0, 1);
        chk("ready_pending_at_rise", rdy_pend, 0);
        cur_rdy = -1;
        if (exp_q.size() != 0) begin
          ex = exp_q.pop_front();
          chk("pulse_rs", lcd_rs, ex.rs);
          chk("pulse_nibble", lcd_nibble, ex.nib);
          if (ex.gap >= 0) chk("low_gap_before_pulse", low_cnt, ex.gap);
          cur_rdy = ex.rdy;
        end
        chk("setup_stable", (h1 == cur) && (h2 == cur), 1);
        pulse_val = cur; high_cnt = 1; stab_bad = 1'b0;
      end else if (lcd_e) begin
        high_cnt++;
        if (cur != pulse_val) stab_bad = 1'b1;
      end else if (prev_e) begin
        chk("pulse_width", high_cnt, 12);
        chk("hold_stable", cur, pulse_val);
        chk("pulse_stable", stab_bad, 0);
        low_cnt = 1;
        if (cur_rdy >= 0) begin rdy_pend = 1'b1; rdy_tgt = cur_rdy; end
      end else begin
        low_cnt++;
        if (rdy_pend && wr_ready) begin
          chk("ready_delay_after_fall", low_cnt, rdy_tgt);
          chk("init_done_with_ready", init_done, 1);
          rdy_pend = 1'b0;
        end
      end
      prev_e = lcd_e;
    end
    h2 = h1; h1 = cur;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, rises;
    logic pe;
    rst = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {wr_ready, init_done, sf_e, lcd_e, lcd_rs, lcd_rw, lcd_nibble},
        10'b00_1_0_0_0_0000);

    // Power-on + config with a byte already waiting (must wait for IDLE)
    push_init();
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    @(negedge clk);
    chk("no_ready_during_init", wr_ready, 0);
    wait_accept(a1);
    @(posedge clk); #1 wr_valid = 1'b0;
    wait_ready();

    // Single data byte
    @(posedge clk); #1 wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h48;
    wait_accept(a1);
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("ready_drops_after_accept", wr_ready, 0);
    wait_ready();

    // Clear then data, valid held: spacing 2*15 + 3 + 9 + 1 = 43
    @(posedge clk); #1 wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'h01;
    wait_accept(a1);
    @(posedge clk); #1 wr_rs = 1'b1; wr_data = 8'h65;
    wait_accept(a2);
    @(posedge clk); #1 wr_valid = 1'b0;
    chk("clear_byte_spacing", a2 - a1, 43);
    wait_ready();
    chk("queue_drained_after_writes", exp_q.size(), 0);

    // Reset during the low-nibble pulse
    @(posedge clk); #1 wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h7E;
    wait_accept(a1);
    @(posedge clk); #1 wr_valid = 1'b0;
    rises = 0; pe = 1'b0;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge clk);
      if (lcd_e && !pe) rises++;
      pe = lcd_e;
    end
    chk("low_nibble_pulse_seen", rises, 2);
    @(posedge clk); #1 rst = 1'b1;
    push_init();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_lcd_e", lcd_e, 0);
    chk("abort_wr_ready", wr_ready, 0);
    chk("abort_init_done", init_done, 0);
    wait_ready();
    repeat (5) @(negedge clk);
    chk("queue_drained_final", exp_q.size(), 0);
    chk("sf_e_const", sf_e, 1);
    chk("lcd_rw_const", lcd_rw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
